bin2bcd_seg: RTL and testbench
==============================

BIN2BCD_SEG -- requirements
Module: bin2bcd_seg

Interface
REQ-001 Parameter BIN_W, default 20: width of the binary input.
REQ-002 Parameter DIGITS, default 6: number of BCD digits produced; DIGITS*4 = 24 matches the display data width.
REQ-003 Parameter MAX_VAL, default 999_999: largest value representable on the display.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 bin  input  BIN_W  unsigned binary value to convert; sampled only on an accepted start.
REQ-007 start  input  1  conversion request; level-sampled each cycle.
REQ-008 busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
REQ-009 done  output  1  one-cycle pulse; dis_data is updated in the same cycle.
REQ-010 ovf  output  1  high when the last accepted bin exceeded MAX_VAL; held until the next done.
REQ-011 dis_data  output  DIGITS*4  packed BCD, bits [23:20] most significant digit, bits [3:0] least significant; feeds the 6-digit display driver directly.

Function
REQ-012 The FSM shall have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block shall capture bin into a shift register, clear the BCD accumulator and the shift counter, and go to SHIFT on the next edge.
REQ-014 In IDLE with start=0, the block shall remain in IDLE, with dis_data and ovf held.
REQ-015 Each SHIFT cycle shall run one double-dabble step: add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left one bit.
REQ-016 SHIFT shall last exactly BIN_W cycles, counted by a counter of width clog2(BIN_W+1); the next state after the last step shall be DONE.
REQ-017 In DONE, for one cycle, the block shall load the accumulator into dis_data, assert done, and update ovf; the next state shall be IDLE.
REQ-018 Latency: start accepted at edge T; SHIFT occupies T+1..T+20; done=1 and new dis_data at T+21; IDLE at T+22.
REQ-019 With start held high, conversions shall repeat every BIN_W+2 = 22 cycles with no lost or merged done pulses.
REQ-020 start while busy=1 (including the DONE cycle) shall be ignored, not queued, and the latched operand shall be unaffected.
REQ-021 A captured value > MAX_VAL shall give dis_data = all ones (24'hFFFFFF) and ovf=1; the accumulator result shall be discarded.
REQ-022 A captured value <= MAX_VAL shall give ovf=0 and exact BCD of the value, leading zeros included (no blanking).
REQ-023 dis_data shall change only in the DONE cycle, so the downstream display never sees partial results.
REQ-024 busy shall be combinationally equal to (state != IDLE); done shall be registered.
REQ-025 An unreachable state encoding shall return to IDLE on the next edge.

Reset
REQ-026 rst=1 at a clock edge shall force state IDLE, counter 0, shift register and accumulator 0, dis_data 24'h000000, done 0, ovf 0, busy 0.
REQ-027 rst shall take priority over start and over any in-progress conversion; an aborted conversion shall never produce done.
REQ-028 After rst is released, the first start shall be accepted in the first IDLE cycle.

Verification
REQ-029 Reset, then start with bin=0 -> done at T+21, dis_data=24'h000000, ovf=0.
REQ-030 bin=123456 -> dis_data=24'h123456 exactly at T+21 with a one-cycle done; dis_data=24'h000000 at T+20.
REQ-031 bin=999999 -> 24'h999999, ovf=0; then bin=1000000 -> 24'hFFFFFF, ovf=1; then bin=7 -> 24'h000007, ovf=0.
REQ-032 start pulsed at T+5 and T+21 with bin changed to 42 during busy -> only one done (T+21), result from the bin captured at T; the next accepted start is at T+22 or later.
REQ-033 Assert rst at T+10 of a conversion of 555555 -> no done, dis_data=24'h000000, busy=0; then a fresh start with 31 -> 24'h000031 after 21 cycles.
REQ-034 start held high for 100 cycles with bin=654321 -> done pulses exactly 22 cycles apart, each with dis_data=24'h654321.

Source files
------------

// File: rtl/bin2bcd_seg.sv
// Sequential binary-to-BCD converter (double dabble) feeding a 6-digit display.
// Out-of-range inputs show all ones and raise ovf until the next result.
module bin2bcd_seg #(
  parameter int BIN_W   = 20,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 999_999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIGITS*4-1:0]   dis_data
);

  localparam int                CNT_W   = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0]  MAX_BIN = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]      sr_q, sr_d;
  logic [DIGITS*4-1:0]   acc_q, acc_d;
  logic [DIGITS*4-1:0]   dis_q, dis_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [DIGITS*4-1:0]   adj;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    dis_d      = dis_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    adj        = acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = bin;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin > MAX_BIN);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        {acc_d, sr_d} = {adj, sr_q} << 1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        // The overflow decision was made at capture, since the operand is shifted away by now.
        done_d  = 1'b1;
        ovf_d   = ovf_pend_q;
        dis_d   = ovf_pend_q ? '1 : acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      acc_q      <= '0;
      dis_q      <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      dis_q      <= dis_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign dis_data = dis_q;

endmodule

// File: tb/tb_bin2bcd_seg.sv
// Directed and randomized checks of bin2bcd_seg against a decimal-arithmetic model.
module tb_bin2bcd_seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] bin;
  logic        start;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [23:0] dis_data;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] model_dis;
  logic        model_ovf;

  bin2bcd_seg #(.BIN_W(20), .DIGITS(6), .MAX_VAL(999_999)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin      (bin),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .dis_data (dis_data)
  );

  always #5 clk = ~clk;

  // Decimal digits extracted by division, not by shifting.
  function automatic logic [23:0] bcdRef(input int unsigned v);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    if (v > 999_999) return 24'hFFFFFF;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion, with start accepted at edge T and result checked at T+21.
  task automatic applyStimulus(input logic [19:0] value);
    int early;
    early = 0;
    bin   = value;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) early++;
      if (k == 20) checkOutput("dis_held_T20", 32'(dis_data), 32'(model_dis));
    end
    checkOutput("no_early_done", 32'(early), 32'd0);
    tick();
    model_dis = bcdRef(32'(value));
    model_ovf = (value > 20'd999_999);
    checkOutput("done_T21", 32'(done), 32'd1);
    checkOutput("dis_T21", 32'(dis_data), 32'(model_dis));
    checkOutput("ovf_T21", 32'(ovf), 32'(model_ovf));
    tick();
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("idle_T22", 32'(busy), 32'd0);
  endtask

  initial begin
    int          cnt;
    int          last_done;
    logic [19:0] rv;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    model_dis = '0;
    model_ovf = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_dis", 32'(dis_data), 32'd0);
    rst = 1'b0;

    $display("[TB] zero, 123456 and range boundaries");
    applyStimulus(20'd0);
    applyStimulus(20'd123456);
    applyStimulus(20'd999999);
    applyStimulus(20'd1000000);
    repeat (3) tick();
    checkOutput("ovf_held_idle", 32'(ovf), 32'd1);
    checkOutput("dis_held_idle", 32'(dis_data), 32'hFFFFFF);
    applyStimulus(20'd7);
    applyStimulus(20'hFFFFF);

    $display("[TB] randomized operands");
    for (int n = 0; n < 8; n++) begin
      rv = 20'($urandom_range(1048575, 0));
      if (n % 3 == 0) rv = 20'($urandom_range(999999, 0));
      applyStimulus(rv);
    end

    $display("[TB] start while busy is ignored");
    bin   = 20'd314159;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin
        bin   = 20'd42;
        start = 1'b1;
      end
      if (k == 6) start = 1'b0;
      if (k == 20) start = 1'b1;
      tick();
      if (done) cnt++;
    end
    checkOutput("busy_no_done", 32'(cnt), 32'd0);
    tick();
    start = 1'b0;
    model_dis = bcdRef(314159);
    model_ovf = 1'b0;
    checkOutput("busy_done_T21", 32'(done), 32'd1);
    checkOutput("busy_dis_orig", 32'(dis_data), 32'(model_dis));
    checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done || busy) cnt++;
    end
    checkOutput("no_queued_start", 32'(cnt), 32'd0);

    $display("[TB] reset aborts a conversion");
    bin   = 20'd555555;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_dis = '0;
    model_ovf = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_dis", 32'(dis_data), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) cnt++;
    end
    checkOutput("abort_no_done", 32'(cnt), 32'd0);
    applyStimulus(20'd31);

    $display("[TB] start held high");
    bin       = 20'd654321;
    start     = 1'b1;
    cnt       = 0;
    last_done = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (done) begin
        if (cnt == 0) checkOutput("held_first_done", 32'(c), 32'd22);
        else checkOutput("held_spacing", 32'(c - last_done), 32'd22);
        checkOutput("held_dis", 32'(dis_data), 32'(bcdRef(654321)));
        last_done = c;
        cnt++;
      end
    end
    checkOutput("held_pulses", 32'(cnt), 32'd4);
    start = 1'b0;
    repeat (25) tick();
    checkOutput("held_final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
